speed_test_readout_seq: RTL and testbench
=========================================

// Module: speed_test_readout_seq
// PURPOSE
//  Sequencer that drives the ring-oscillator speed-test macro's 8-bit input bus and consumes its 8-bit output bus.
//  Arms both rings, fires one measurement window, checks the fired flag, and reads the two 24-bit down-counters
//  byte by byte via the select mux. It then presents edge counts and health flags on a valid/ready result port.
// PARAMETERS
//  TRIG_CYCLES   2  clocks meas_trig is held high (>=1)
//  SETTLE_CYCLES 3  clocks waited after trig drops before checking the fired bit (>=1)
//  READ_WAIT     1  clocks between meas_sel update and byte sample (>=1)
//  MAX_DELTA     3  max |count0-count1| before mismatch is flagged
//  MIN_COUNT     10 raw count below this sets the too-small flag
// PORTS
//  clk          in  1   system clock
//  rst          in  1   synchronous, active-high reset
//  start        in  1   pulse: begin one measurement; ignored unless state is IDLE
//  busy         out 1   high in every state except IDLE
//  meas_nrst    out 1   to macro nrst
//  meas_trig    out 1   to macro trig
//  meas_sel     out 3   to macro sel
//  meas_ring_en out 2   to macro ring_en
//  meas_data    in  8   from macro io_out; bit6 = fired, bit7 = debug high when sel=111
//  res_valid    out 1   result available
//  res_ready    in  1   consumer accepts result
//  edges0       out 24  24'hFFFFFF - count0
//  edges1       out 24  24'hFFFFFF - count1
//  err_code     out 3   0 ok; 1 fired already set; 2 no fire; 3 debug bit low
//  flags        out 4   {mismatch, too_small, ovf1, ovf0}
// BEHAVIOUR
//  - All outputs are registered. Reset values: meas_nrst=0, meas_trig=0, meas_sel=000, meas_ring_en=00, busy=0.
//    Reset values: res_valid=0, edges0=edges1=0, err_code=0, flags=0. State = IDLE.
//  - rst asserted in any state returns to the reset values on the next edge. Rings stop, and any held result is dropped.
//  - IDLE: meas_nrst=0. On start=1 -> ARM, driving meas_nrst=1, meas_sel=111, meas_ring_en=11.
//  - ARM (1 clk) -> CHK0.
//  - CHK0 (1 clk): sample meas_data.
//    - bit7=0 -> ERR with code 3.
//    - bit6=1 -> ERR with code 1.
//    - Otherwise -> FIRE with meas_trig=1.
//  - FIRE: hold meas_trig=1 for TRIG_CYCLES clocks. Then meas_trig=0 -> SETTLE.
//  - SETTLE: wait SETTLE_CYCLES clocks -> CHK1.
//  - CHK1 (1 clk): if meas_data[6]=0 -> ERR with code 2. Otherwise set meas_ring_en=00 -> READ.
//  - READ: byte index i=0..5 with sel table 000,001,010,100,101,110.
//    - Dest bytes: c0[7:0], c0[15:8], c0[23:16], c1[7:0], c1[15:8], c1[23:16].
//    - On READ entry meas_sel=table[0].
//    - At the edge ending READ_WAIT clocks with meas_sel=table[i]: capture meas_data into byte i,
//      and on the same edge load meas_sel=table[i+1]. The captured data reflects the old select.
//    - After i=5 -> CALC.
//  - CALC (1 clk), all 24-bit unsigned arithmetic:
//    - edges0/edges1 per port definitions.
//    - ovfN = ~cN[23].
//    - too_small = (c0<MIN_COUNT)|(c1<MIN_COUNT).
//    - mismatch = |c0-c1| > MAX_DELTA, computed with no wrap.
//    - err_code=0, then res_valid=1 -> DONE.
//  - ERR (1 clk): meas_trig=0, meas_ring_en=00, edges=0, flags=0, err_code set, res_valid=1 -> DONE.
//  - DONE: outputs held stable while res_valid=1 and res_ready=0. res_ready=1 completes the transfer at that edge:
//    res_valid=0, meas_nrst=0, meas_sel=000, back to IDLE.
//  - res_ready with res_valid=0 is ignored. start during a busy state is dropped, not queued.
//  - Latency with default params: start sampled at edge E0 -> res_valid=1 after edge E0+15.
// TESTING
//  - Model macro returns c0=c1=24'hFFF000, fired bit goes 0->1 after trig. Expect res_valid at E0+15,
//    edges0=edges1=24'h000FFF, err_code=0, flags=0.
//  - c0=24'hFFF000, c1=24'hFFEFFC (delta 4). Expect flags[3]=1 (mismatch).
//    c1=24'hFFEFFD (delta 3) -> mismatch=0.
//  - c0=24'h7FFFF0 -> ovf0=1, edges0=24'h80000F. c1=24'h000005 -> too_small=1 and ovf1=1.
//  - Fired bit already 1 in CHK0 -> err_code=1, meas_trig never asserted.
//    Fired bit never rises -> err_code=2, ring_en=00.
//  - Hold res_ready=0 for 10 clks -> outputs stable. start pulses during busy are ignored.
//    res_ready=1 -> IDLE the next edge.
//  - Assert rst during READ (i=3) -> next edge shows all reset values. A new start completes normally.

Source files
------------

// File: rtl/speed_test_readout_seq.sv
`default_nettype none
// ============================================================================
// Module   : speed_test_readout_seq
// Brief    : Arms the ring-oscillator speed-test macro, fires one window and
//            reads back both 24-bit down-counters onto a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module speed_test_readout_seq #(
    parameter int TRIG_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int READ_WAIT     = 1,
    parameter int MAX_DELTA     = 3,
    parameter int MIN_COUNT     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        meas_nrst,
    output logic        meas_trig,
    output logic [2:0]  meas_sel,
    output logic [1:0]  meas_ring_en,
    input  logic [7:0]  meas_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] edges0,
    output logic [23:0] edges1,
    output logic [2:0]  err_code,
    output logic [3:0]  flags
);

    localparam logic [7:0]  TRIG_LAST   = 8'(TRIG_CYCLES - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  READ_LAST   = 8'(READ_WAIT - 1);
    localparam logic [23:0] MAX_D       = 24'(MAX_DELTA);
    localparam logic [23:0] MIN_C       = 24'(MIN_COUNT);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ARM    = 4'd1,
        S_CHK0   = 4'd2,
        S_FIRE   = 4'd3,
        S_SETTLE = 4'd4,
        S_CHK1   = 4'd5,
        S_READ   = 4'd6,
        S_CALC   = 4'd7,
        S_ERR    = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  idx;
    logic [2:0]  err_pend;
    logic [23:0] c0;
    logic [23:0] c1;
    logic [23:0] diff;

    // Byte order: c0 low..high via sel 0..2, then c1 low..high via sel 4..6.
    function automatic logic [2:0] sel_of(input logic [2:0] i);
        case (i)
            3'd0:    sel_of = 3'b000;
            3'd1:    sel_of = 3'b001;
            3'd2:    sel_of = 3'b010;
            3'd3:    sel_of = 3'b100;
            3'd4:    sel_of = 3'b101;
            default: sel_of = 3'b110;
        endcase
    endfunction

    assign diff = (c0 >= c1) ? (c0 - c1) : (c1 - c0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            meas_nrst    <= 1'b0;
            meas_trig    <= 1'b0;
            meas_sel     <= 3'b000;
            meas_ring_en <= 2'b00;
            res_valid    <= 1'b0;
            edges0       <= '0;
            edges1       <= '0;
            err_code     <= '0;
            flags        <= '0;
            cnt          <= '0;
            idx          <= '0;
            err_pend     <= '0;
            c0           <= '0;
            c1           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_ARM;
                        busy         <= 1'b1;
                        meas_nrst    <= 1'b1;
                        meas_sel     <= 3'b111;
                        meas_ring_en <= 2'b11;
                    end
                end
                S_ARM: state <= S_CHK0;
                S_CHK0: begin
                    if (!meas_data[7]) begin
                        err_pend <= 3'd3;
                        state    <= S_ERR;
                    end else if (meas_data[6]) begin
                        err_pend <= 3'd1;
                        state    <= S_ERR;
                    end else begin
                        meas_trig <= 1'b1;
                        cnt       <= '0;
                        state     <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    if (cnt == TRIG_LAST) begin
                        meas_trig <= 1'b0;
                        cnt       <= '0;
                        state     <= S_SETTLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_CHK1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_CHK1: begin
                    if (!meas_data[6]) begin
                        err_pend <= 3'd2;
                        state    <= S_ERR;
                    end else begin
                        meas_ring_en <= 2'b00;
                        meas_sel     <= sel_of(3'd0);
                        idx          <= '0;
                        cnt          <= '0;
                        state        <= S_READ;
                    end
                end
                S_READ: begin
                    if (cnt == READ_LAST) begin
                        cnt <= '0;
                        // Captured byte belongs to the select that was applied, not the one loaded now.
                        case (idx)
                            3'd0:    c0[7:0]   <= meas_data;
                            3'd1:    c0[15:8]  <= meas_data;
                            3'd2:    c0[23:16] <= meas_data;
                            3'd3:    c1[7:0]   <= meas_data;
                            3'd4:    c1[15:8]  <= meas_data;
                            default: c1[23:16] <= meas_data;
                        endcase
                        if (idx == 3'd5) begin
                            meas_sel <= 3'b000;
                            state    <= S_CALC;
                        end else begin
                            idx      <= idx + 3'd1;
                            meas_sel <= sel_of(idx + 3'd1);
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_CALC: begin
                    edges0    <= 24'hFFFFFF - c0;
                    edges1    <= 24'hFFFFFF - c1;
                    flags     <= {diff > MAX_D, (c0 < MIN_C) | (c1 < MIN_C), ~c1[23], ~c0[23]};
                    err_code  <= 3'd0;
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_ERR: begin
                    meas_trig    <= 1'b0;
                    meas_ring_en <= 2'b00;
                    edges0       <= '0;
                    edges1       <= '0;
                    flags        <= '0;
                    err_code     <= err_pend;
                    res_valid    <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        meas_nrst <= 1'b0;
                        meas_sel  <= 3'b000;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_speed_test_readout_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_speed_test_readout_seq
// Brief    : Bench with a behavioural speed-test macro and result reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_speed_test_readout_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        meas_nrst;
    logic        meas_trig;
    logic [2:0]  meas_sel;
    logic [1:0]  meas_ring_en;
    logic [7:0]  meas_data;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] edges0;
    logic [23:0] edges1;
    logic [2:0]  err_code;
    logic [3:0]  flags;

    int n_total = 0;
    int n_bad   = 0;

    // Macro model controls: 0 normal, 1 fired early, 2 never fires, 3 debug bit low
    logic [23:0] m_c0;
    logic [23:0] m_c1;
    int          m_mode;
    logic        fired;
    int          trig_cnt;

    always #5 clk = ~clk;

    speed_test_readout_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .meas_nrst    (meas_nrst),
        .meas_trig    (meas_trig),
        .meas_sel     (meas_sel),
        .meas_ring_en (meas_ring_en),
        .meas_data    (meas_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .edges0       (edges0),
        .edges1       (edges1),
        .err_code     (err_code),
        .flags        (flags)
    );

    always @(posedge clk) begin
        if (!meas_nrst)        fired <= 1'b0;
        else if (m_mode == 1)  fired <= 1'b1;
        else if (m_mode == 0 && meas_trig) fired <= 1'b1;
        if (meas_trig) trig_cnt <= trig_cnt + 1;
    end

    always_comb begin
        meas_data = 8'h00;
        case (meas_sel)
            3'b111: meas_data = {(m_mode != 3), fired, 6'b0};
            3'b000: meas_data = m_c0[7:0];
            3'b001: meas_data = m_c0[15:8];
            3'b010: meas_data = m_c0[23:16];
            3'b100: meas_data = m_c1[7:0];
            3'b101: meas_data = m_c1[15:8];
            3'b110: meas_data = m_c1[23:16];
            default: meas_data = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction against the reference model; hold = clocks res_ready stays low.
    task automatic run_case(input logic [23:0] c0, input logic [23:0] c1, input int mode, input int hold);
        longint      d;
        int          exp_lat;
        int          exp_err;
        logic [23:0] exp_e0;
        logic [23:0] exp_e1;
        logic [3:0]  exp_f;
        int          lat;
        int          t0;
        logic [63:0] snap;
        m_c0   = c0;
        m_c1   = c1;
        m_mode = mode;
        t0     = trig_cnt;
        d      = longint'(c0) - longint'(c1);
        if (d < 0) d = -d;
        exp_e0 = 24'(16777215 - int'(c0));
        exp_e1 = 24'(16777215 - int'(c1));
        exp_f  = {d > 3, (c0 < 10) || (c1 < 10), c1 < 24'd8388608, c0 < 24'd8388608};
        exp_err = 0;
        exp_lat = 15;
        if (mode == 3)      begin exp_err = 3; exp_lat = 3; end
        else if (mode == 1) begin exp_err = 1; exp_lat = 3; end
        else if (mode == 2) begin exp_err = 2; exp_lat = 9; end
        if (mode != 0) begin exp_e0 = 0; exp_e1 = 0; exp_f = 0; end

        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (res_valid) begin lat = k - 1; break; end
            tick();
        end
        if (!res_valid) lat = -1;
        check("latency", 64'(lat), 64'(exp_lat));
        check("edges0", 64'(edges0), 64'(exp_e0));
        check("edges1", 64'(edges1), 64'(exp_e1));
        check("err_code", 64'(err_code), 64'(exp_err));
        check("flags", 64'(flags), 64'(exp_f));
        check("busy_done", 64'(busy), 64'd1);
        check("ring_off", 64'(meas_ring_en), 64'd0);
        check("trig_seen", 64'(trig_cnt != t0), 64'(mode == 0 || mode == 2));

        snap = {res_valid, edges0, edges1, err_code, flags, busy, 7'b0};
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            check("hold_stable", {res_valid, edges0, edges1, err_code, flags, busy, 7'b0}, snap);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("post_valid", 64'(res_valid), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_nrst_sel", 64'({meas_nrst, meas_sel}), 64'd0);
        tick();
        check("start_dropped", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] b;
        int          md;
        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        m_c0 = 0; m_c1 = 0; m_mode = 0; trig_cnt = 0;
        repeat (3) tick();
        check("rst_outs", {busy, meas_nrst, meas_trig, meas_sel, meas_ring_en, res_valid, err_code, flags},
              64'd0);
        check("rst_edges", {edges0, edges1}, 64'd0);
        rst = 1'b0;
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("idle_ready_ignored", 64'({busy, res_valid}), 64'd0);

        run_case(24'hFFF000, 24'hFFF000, 0, 0);
        run_case(24'hFFF000, 24'hFFEFFC, 0, 1);
        run_case(24'hFFF000, 24'hFFEFFD, 0, 0);
        run_case(24'h7FFFF0, 24'h000005, 0, 0);
        run_case(24'hFFF000, 24'hFFF000, 1, 0);
        run_case(24'hFFF000, 24'hFFF000, 2, 0);
        run_case(24'hFFF000, 24'hFFF000, 3, 0);
        run_case(24'h00000A, 24'h00000D, 0, 10);

        // Reset during READ while byte index 3 is pending
        m_c0 = 24'h123456; m_c1 = 24'h123457; m_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outs", {busy, meas_nrst, meas_trig, meas_sel, meas_ring_en, res_valid, err_code, flags},
              64'd0);
        check("midrst_edges", {edges0, edges1}, 64'd0);
        tick();
        run_case(24'hABCDEF, 24'hABCDF1, 0, 0);

        for (int r = 0; r < 20; r++) begin
            a  = 24'($urandom_range(0, 24'hFFFFF0));
            b  = ($urandom_range(0, 1) == 1) ? 24'(a + 24'($urandom_range(0, 6))) : 24'($urandom);
            md = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_case(a, b, md, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
